// File: rtl/dottori_pkg.sv
// Shared types for the ROM download path: loader FSM states and the HPS slot
// index that carries the game ROM.
package dottori_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_READY,
    ST_FAIL
  } rom_ld_state_t;

  localparam logic [7:0] ROM_INDEX = 8'd0;

endpackage

// File: rtl/rom_loader_cksum.sv
// Accepted-byte counter (saturating) and 16-bit modular byte sum. A clear
// that coincides with an accumulate seeds both with that byte.
module rom_loader_cksum #(
  parameter int CNT_W = 15
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             acc,
  input  logic [7:0]       data,
  output logic [CNT_W-1:0] byte_count,
  output logic [15:0]      checksum
);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      byte_count <= '0;
      checksum   <= '0;
    end else if (clr) begin
      byte_count <= {{(CNT_W-1){1'b0}}, acc};
      checksum   <= acc ? {8'h00, data} : 16'h0000;
    end else if (acc) begin
      if (byte_count != '1) byte_count <= byte_count + 1'b1;
      checksum <= checksum + {8'h00, data};
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Bridges HPS ioctl downloads into the core's ROM write port, validates the
// image and holds the core in reset until a good image has settled.
module rom_loader
  import dottori_pkg::*;
#(
  parameter int          ADDR_W      = 14,
  parameter int          ROM_BYTES   = 16384,
  parameter int          CHECK_EN    = 1,
  parameter logic [15:0] EXPECT_SUM  = 16'h0000,
  parameter int          RELEASE_DLY = 16
) (
  input  logic              CLK_4M,
  input  logic              nRESET,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic              core_nreset,
  output logic              rom_ready,
  output logic              rom_error,
  output logic              loading,
  output logic [ADDR_W:0]   byte_count,
  output logic [15:0]       checksum
);

  localparam int                CNT_W    = ADDR_W + 1;
  localparam int                RC_W     = (RELEASE_DLY > 0) ? $clog2(RELEASE_DLY + 1) : 1;
  localparam logic [RC_W-1:0]   REL_MAX  = RC_W'(RELEASE_DLY);
  localparam logic [24:0]       ROM_LIM  = 25'(ROM_BYTES);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(ROM_BYTES);

  rom_ld_state_t   state, state_nxt;
  logic            rom_start, start, take, in_range, accept, drop, overrun, pass;
  logic [RC_W-1:0] rel_cnt;

  assign rom_start = ioctl_download && (ioctl_index == ROM_INDEX);
  assign start     = rom_start && (state inside {ST_IDLE, ST_READY, ST_FAIL});
  // The start cycle already counts as LOAD for an incoming byte.
  assign take      = ioctl_wr && (start || (state == ST_LOAD));
  assign in_range  = ioctl_addr < ROM_LIM;
  assign accept    = take && in_range;
  assign drop      = take && !in_range;
  assign pass      = (byte_count == CNT_FULL) && !overrun &&
                     ((CHECK_EN == 0) || (checksum == EXPECT_SUM));

  always_ff @(posedge CLK_4M) begin
    if (!nRESET) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_READY, ST_FAIL: if (rom_start) state_nxt = ST_LOAD;
      ST_LOAD:                    if (!ioctl_download) state_nxt = ST_CHECK;
      ST_CHECK:                   state_nxt = pass ? ST_READY : ST_FAIL;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_4M) begin
    if (!nRESET) begin
      dn_wr   <= 1'b0;
      dn_addr <= '0;
      dn_data <= '0;
      overrun <= 1'b0;
      rel_cnt <= '0;
    end else begin
      dn_wr <= accept;
      if (accept) begin
        dn_addr <= ioctl_addr[ADDR_W-1:0];
        dn_data <= ioctl_dout;
      end
      if (start)     overrun <= drop;
      else if (drop) overrun <= 1'b1;
      // Counter parks at REL_MAX so core_nreset stays high for the rest of READY.
      if (start)                                     rel_cnt <= '0;
      else if ((state == ST_READY) && (rel_cnt != REL_MAX)) rel_cnt <= rel_cnt + 1'b1;
    end
  end

  rom_loader_cksum #(.CNT_W(CNT_W)) u_cksum (
    .clk        (CLK_4M),
    .nrst       (nRESET),
    .clr        (start),
    .acc        (accept),
    .data       (ioctl_dout),
    .byte_count (byte_count),
    .checksum   (checksum)
  );

  assign loading     = (state == ST_LOAD);
  assign rom_ready   = (state == ST_READY);
  assign rom_error   = (state == ST_FAIL);
  assign core_nreset = (state == ST_READY) && (rel_cnt == REL_MAX);

endmodule

// File: tb/tb_rom_loader.sv
// Randomized scoreboard bench for rom_loader: two instances share stimulus,
// one count-only with a long release delay, one checksum-checked with no delay.
module tb_rom_loader;

  localparam int ROM_BYTES = 16384;
  localparam int DLY0      = 16;
  localparam int SUM1      = 'h1234;

  logic        clk = 1'b0, nrst = 1'b0, dl = 1'b0, wr = 1'b0;
  logic [7:0]  idx = 8'd0, dout = 8'd0;
  logic [24:0] addr = '0;

  logic [13:0] d0_addr, d1_addr;
  logic [7:0]  d0_data, d1_data;
  logic        d0_wr, d1_wr, d0_nrst, d1_nrst, d0_rdy, d1_rdy, d0_err, d1_err, d0_ld, d1_ld;
  logic [14:0] d0_cnt, d1_cnt;
  logic [15:0] d0_sum, d1_sum;

  rom_loader #(.CHECK_EN(0), .RELEASE_DLY(DLY0)) dut0 (
    .CLK_4M(clk), .nRESET(nrst), .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .dn_addr(d0_addr), .dn_data(d0_data), .dn_wr(d0_wr),
    .core_nreset(d0_nrst), .rom_ready(d0_rdy), .rom_error(d0_err), .loading(d0_ld),
    .byte_count(d0_cnt), .checksum(d0_sum));

  rom_loader #(.CHECK_EN(1), .EXPECT_SUM(16'h1234), .RELEASE_DLY(0)) dut1 (
    .CLK_4M(clk), .nRESET(nrst), .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .dn_addr(d1_addr), .dn_data(d1_data), .dn_wr(d1_wr),
    .core_nreset(d1_nrst), .rom_ready(d1_rdy), .rom_error(d1_err), .loading(d1_ld),
    .byte_count(d1_cnt), .checksum(d1_sum));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int a; int d; int due; } exp_t;
  exp_t sbq[$];
  int   img_a[$], img_d[$];
  int   tests = 0, fails = 0;
  int   m_cnt, m_sum, m_ovr;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every expected ROM write must appear on both instances exactly on its due cycle.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        exp_t e;
        e = sbq.pop_front();
        chk("dn_wr0", d0_wr, 1);
        chk("dn_addr0", d0_addr, e.a);
        chk("dn_data0", d0_data, e.d);
        chk("dn_wr1", d1_wr, 1);
        chk("dn_addr1", d1_addr, e.a);
        chk("dn_data1", d1_data, e.d);
      end else if (d0_wr || d1_wr) begin
        chk("dn_wr spurious", {d1_wr, d0_wr}, 0);
      end
    end
  endtask

  task automatic build(input int n, input bit pattern);
    img_a.delete(); img_d.delete();
    for (int i = 0; i < n; i++) begin
      img_a.push_back(i);
      img_d.push_back(pattern ? (i & 255) : int'($urandom_range(0, 255)));
    end
  endtask

  // Nudge bytes so the first n of the image sum to target mod 2^16.
  task automatic fix_sum(input int n, input int target);
    int s = 0;
    int diff;
    for (int i = 0; i < n; i++) s += img_d[i];
    diff = (target - s) & 'hffff;
    if (diff >= 32768) diff -= 65536;
    for (int i = 0; i < n && diff != 0; i++) begin
      int room;
      int step;
      room = (diff > 0) ? 255 - img_d[i] : img_d[i];
      step = ((diff > 0 ? diff : -diff) < room) ? (diff > 0 ? diff : -diff) : room;
      if (diff > 0) begin img_d[i] += step; diff -= step; end
      else          begin img_d[i] -= step; diff += step; end
    end
  endtask

  task automatic run_dl(input int n, input bit fall);
    exp_t e;
    m_cnt = 0; m_sum = 0; m_ovr = 0;
    dl = 1'b1; idx = 8'd0;
    for (int i = 0; i < n; i++) begin
      wr = 1'b1; addr = 25'(img_a[i]); dout = 8'(img_d[i]);
      if (fall && i == n - 1) dl = 1'b0;
      if (img_a[i] < ROM_BYTES) begin
        e.a = img_a[i]; e.d = img_d[i]; e.due = cyc + 1;
        sbq.push_back(e);
        m_cnt++;
        m_sum = (m_sum + img_d[i]) & 'hffff;
      end else m_ovr = 1;
      @(posedge clk); #1;
      if (i == 0) begin
        chk("start nreset0", d0_nrst, 0);
        chk("start nreset1", d1_nrst, 0);
        chk("start ready0", d0_rdy, 0);
        chk("start error1", d1_err, 0);
        chk("start loading", {d1_ld, d0_ld}, 3);
        chk("start count0", d0_cnt, m_cnt);
        chk("start sum0", d0_sum, m_sum);
        chk("start count1", d1_cnt, m_cnt);
      end
    end
    wr = 1'b0;
  endtask

  // Called #1 after the edge that sees download low; core_nreset must rise
  // exactly RELEASE_DLY+1 edges later on a passing image.
  task automatic check_end(input string tag);
    bit pass0, pass1;
    pass0 = (m_cnt == ROM_BYTES) && !m_ovr;
    pass1 = pass0 && (m_sum == SUM1);
    chk({tag, " check nreset0"}, d0_nrst, 0);
    chk({tag, " check loading0"}, d0_ld, 0);
    for (int k = 1; k <= DLY0 + 3; k++) begin
      @(posedge clk); #1;
      chk({tag, " nreset0"}, d0_nrst, int'(pass0 && k >= DLY0 + 1));
      chk({tag, " nreset1"}, d1_nrst, int'(pass1));
    end
    chk({tag, " ready0"}, d0_rdy, pass0);
    chk({tag, " error0"}, d0_err, !pass0);
    chk({tag, " ready1"}, d1_rdy, pass1);
    chk({tag, " error1"}, d1_err, !pass1);
    chk({tag, " count0"}, d0_cnt, m_cnt);
    chk({tag, " sum0"}, d0_sum, m_sum);
    chk({tag, " count1"}, d1_cnt, m_cnt);
    chk({tag, " sum1"}, d1_sum, m_sum);
  endtask

  task automatic rst_check(input string tag);
    chk({tag, " dn_wr"}, {d1_wr, d0_wr}, 0);
    chk({tag, " dn_addr"}, d0_addr, 0);
    chk({tag, " dn_data"}, d0_data, 0);
    chk({tag, " nreset"}, {d1_nrst, d0_nrst}, 0);
    chk({tag, " ready"}, {d1_rdy, d0_rdy}, 0);
    chk({tag, " error"}, {d1_err, d0_err}, 0);
    chk({tag, " loading"}, {d1_ld, d0_ld}, 0);
    chk({tag, " count"}, d0_cnt, 0);
    chk({tag, " sum"}, d0_sum, 0);
  endtask

  initial begin
    int pc, ps;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    rst_check("reset");
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Mostly addr[7:0] pattern, trimmed to sum 0x1233: count-only passes, checksum fails.
    build(ROM_BYTES, 1'b1);
    fix_sum(ROM_BYTES, 'h1233);
    run_dl(ROM_BYTES, 1'b1);
    check_end("happy");

    // Non-ROM slot: nothing moves.
    pc = d0_cnt; ps = d0_sum;
    dl = 1'b1; idx = 8'd1;
    for (int i = 0; i < 10; i++) begin
      wr = 1'b1; addr = 25'($urandom_range(0, ROM_BYTES - 1)); dout = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    wr = 1'b0; dl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idx1 ready0", d0_rdy, 1);
    chk("idx1 nreset0", d0_nrst, 1);
    chk("idx1 count0", d0_cnt, pc);
    chk("idx1 sum0", d0_sum, ps);
    chk("idx1 error1", d1_err, 1);
    idx = 8'd0;

    // Reload from READY with a good-sum image plus one out-of-window write.
    build(ROM_BYTES, 1'b0);
    fix_sum(ROM_BYTES, SUM1);
    img_a.push_back(ROM_BYTES);
    img_d.push_back(int'($urandom_range(0, 255)));
    run_dl(ROM_BYTES + 1, 1'b1);
    check_end("overrun");

    build(ROM_BYTES - 1, 1'b0);
    run_dl(ROM_BYTES - 1, 1'b1);
    check_end("short");

    // Reset after 100 bytes, then a clean good image.
    build(ROM_BYTES, 1'b0);
    fix_sum(ROM_BYTES, SUM1);
    run_dl(100, 1'b0);
    nrst = 1'b0; dl = 1'b0;
    @(posedge clk); #1;
    rst_check("midreset");
    nrst = 1'b1;
    @(posedge clk); #1;
    run_dl(ROM_BYTES, 1'b1);
    check_end("recover");

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
